tcounter_n: RTL



---
 rtl/tcounter_n_pkg.sv | 55 +++++
 rtl/tcounter_n_tff_cell.sv | 24 ++
 rtl/tcounter_n.sv | 85 ++++++++
 3 files changed

// File: rtl/tcounter_n_pkg.sv
// Shared definitions for the tcounter_n counter primitive: direction
// constants and the modulo arithmetic helpers used by the top level.
// The helpers work on a fixed 64-bit datapath so that any legal
// WIDTH/MODULUS combination can share them; callers zero-extend the
// count and keep only the low WIDTH bits of the result.
package tcounter_n_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   localparam int CALC_W = 64;

   typedef logic [CALC_W-1:0] calc_t;

   // Result of one counting step: wrap marks a modulus boundary crossing
   typedef struct packed {
      logic  wrap;
      calc_t next;
   } step_t;

   // Load value clamped into the legal range 0..modulus-1
   function automatic calc_t clamp_load(input calc_t d, input calc_t modulus);
      calc_t result;
      if (d < modulus) begin
         result = d;
      end else begin
         result = modulus - calc_t'(1);
      end
      return result;
   endfunction

   // One step up or down modulo modulus, flagging the wrap-around
   function automatic step_t next_count(input calc_t q, input logic dir, input calc_t modulus);
      step_t result;
      result.wrap = 1'b0;
      result.next = q;
      if (dir == DIR_UP) begin
         if (q == modulus - calc_t'(1)) begin
            result.wrap = 1'b1;
            result.next = '0;
         end else begin
            result.next = q + calc_t'(1);
         end
      end else begin
         if (q == '0) begin
            result.wrap = 1'b1;
            result.next = modulus - calc_t'(1);
         end else begin
            result.next = q - calc_t'(1);
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/tcounter_n_tff_cell.sv
// Single-bit T storage cell. The cell toggles on every rising En edge
// where T is high; the counter drives T with the per-bit toggle vector
// so the cell itself stays as simple as a classic T flip-flop.
module tff_cell (
   input  logic En,
   input  logic Res,
   input  logic T,
   output logic Q
);

   logic state_q;

   // Toggle storage, cleared immediately by the shared asynchronous reset
   always_ff @(posedge En or posedge Res) begin
      if (Res) begin
         state_q <= 1'b0;
      end else if (T) begin
         state_q <= ~state_q;
      end
   end

   assign Q = state_q;

endmodule

// File: rtl/tcounter_n.sv
// Parametrised synchronous modulo counter built from a row of T cells.
// Supports up/down counting, a clamped synchronous load, a combinational
// terminal-count output for cascading, and a registered one-cycle wrap
// flag. All cells share the clock and reset, so every bit changes on the
// same edge.
module tcounter_n
   import tcounter_n_pkg::*;
#(
   parameter int              WIDTH   = 4,
   parameter longint unsigned MODULUS = 16
) (
   input  logic             En,
   input  logic             Res,
   input  logic             T,
   input  logic             Dir,
   input  logic             Pres,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             Tc,
   output logic             Ovf
);

   // Reject configurations the 64-bit helper datapath cannot represent,
   // and moduli outside 2..2^WIDTH
   if (WIDTH < 1 || WIDTH > 63) begin : gBadWidth
      $error("tcounter_n: WIDTH must be in 1..63");
   end else if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : gBadModulus
      $error("tcounter_n: MODULUS must be in 2..2^WIDTH");
   end

   localparam calc_t           MOD_WIDE = calc_t'(MODULUS);
   localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MODULUS - 64'd1);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] toggleVec;
   logic             ovf_q;
   logic             ovf_d;
   calc_t            countWide;
   calc_t            loadWide;
   step_t            stepRes;

   assign countWide = calc_t'(count_q);
   assign loadWide  = clamp_load(calc_t'(D), MOD_WIDE);
   assign stepRes   = next_count(countWide, Dir, MOD_WIDE);

   // Next count and wrap flag, with load taking priority over counting
   always_comb begin
      count_d = count_q;
      ovf_d   = 1'b0;
      if (Pres) begin
         count_d = loadWide[WIDTH-1:0];
      end else if (T) begin
         count_d = stepRes.next[WIDTH-1:0];
         ovf_d   = stepRes.wrap;
      end
   end

   // Each cell flips exactly where the current and next count differ
   assign toggleVec = count_q ^ count_d;

   for (genvar i = 0; i < WIDTH; i++) begin : gCell
      tff_cell uCell (
         .En  (En),
         .Res (Res),
         .T   (toggleVec[i]),
         .Q   (count_q[i])
      );
   end

   // Wrap flag register: one-cycle pulse after each boundary crossing
   always_ff @(posedge En or posedge Res) begin
      if (Res) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign Q   = count_q;
   assign Ovf = ovf_q;
   assign Tc  = T & (((Dir == DIR_UP) & (count_q == TOP_VAL)) |
                     ((Dir == DIR_DOWN) & (count_q == '0)));

endmodule
